// File: rtl/tswitch_pkg.sv
// Shared switch-wide widths.
// Consumed by the per-port multicast write responder.
package tswitch_pkg;
  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;
endpackage

// File: rtl/mc_write_responder.sv
// Per-port multicast write responder: buffers writes, issues them in
// order to node memory, pulses wr_done once per completed write.
// Ports: wr_* request in (valid/ready), mem_req_* out, mem_rsp_* in,
// wr_done pulse, err_count, protocol_err, pending/busy status.
module mc_write_responder #(
  parameter int ADDR_WIDTH      = tswitch_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH      = tswitch_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PEND_W =
    $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_done,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic                  mem_rsp_error,
  output logic [7:0]            err_count,
  output logic                  protocol_err,
  output logic [PEND_W-1:0]     pending,
  output logic                  busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] fifo_cnt;
  logic [OW-1:0]    outstanding;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic rsp_ok;
  logic rsp_bad;

  // Extra pointer bit distinguishes full from empty
  // when the index bits are equal.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign fifo_cnt = wptr - rptr;

  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;

  assign mem_req_valid = !empty &&
    (outstanding < OW'(MAX_OUTSTANDING));
  assign pop = mem_req_valid && mem_req_ready;

  // Head is only driven while a request is offered,
  // so idle outputs read as zero.
  assign mem_req_addr = mem_req_valid ?
    addr_q[rptr[AW-1:0]] : '0;
  assign mem_req_data = mem_req_valid ?
    data_q[rptr[AW-1:0]] : '0;

  // A response in the issue cycle pairs with that
  // issue, so it is legal even at zero outstanding.
  assign rsp_ok  = mem_rsp_valid &&
    ((outstanding != '0) || pop);
  assign rsp_bad = mem_rsp_valid && !rsp_ok;

  assign pending = PEND_W'(fifo_cnt) +
                   PEND_W'(outstanding);
  assign busy    = (pending != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr[AW-1:0]] <= wr_addr;
      data_q[wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      outstanding  <= '0;
      wr_done      <= 1'b0;
      err_count    <= 8'd0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (pop && !rsp_ok) begin
        outstanding <= outstanding + OW'(1);
      end else if (!pop && rsp_ok) begin
        outstanding <= outstanding - OW'(1);
      end
      wr_done <= rsp_ok;
      if (rsp_ok && mem_rsp_error &&
          (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (rsp_bad) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_write_responder.sv
// Scoreboard bench for mc_write_responder: memory model,
// expected-write queue, per-cycle status checks.
module tb_mc_write_responder;
  import tswitch_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam int PW    = $clog2(DEPTH + MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_done;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic          mem_rsp_error;
  logic [7:0]    err_count;
  logic          protocol_err;
  logic [PW-1:0] pending;
  logic          busy;

  always #5 clk = ~clk;

  mc_write_responder #(
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .wr_done(wr_done),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_error(mem_rsp_error),
    .err_count(err_count),
    .protocol_err(protocol_err),
    .pending(pending),
    .busy(busy)
  );

  logic [AW+DW-1:0] fifo_m [$];
  bit pend_rsp [$];
  bit err_q [$];

  int out_m;
  bit exp_done;
  bit prot_m;
  int err_m;
  int n_chk, n_err, n_acc, n_done, cyc;
  bit mem_rdy, auto_rsp, rsp_once, inj_rsp;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit push, iss, rv, re, ok, e;
    logic [AW+DW-1:0] head;
    rv = 1'b0;
    re = 1'b0;
    if (inj_rsp) begin
      rv = 1'b1;
    end else if ((auto_rsp || rsp_once) &&
                 pend_rsp.size() > 0) begin
      rv = 1'b1;
      re = pend_rsp[0];
    end
    mem_rsp_valid = rv;
    mem_rsp_error = re;
    mem_req_ready = mem_rdy;
    push = rst_n && wr_valid && wr_ready;
    iss  = rst_n && mem_req_valid && mem_req_ready;
    if (rst_n) begin
      chk("wr_ready", wr_ready, fifo_m.size() < DEPTH);
      chk("req_valid", mem_req_valid,
          fifo_m.size() > 0 && out_m < MAXO);
      if (iss && fifo_m.size() > 0) begin
        head = fifo_m[0];
        chk("req_addr", mem_req_addr, head[AW+DW-1:DW]);
        chk("req_data", mem_req_data, head[DW-1:0]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      fifo_m.delete();
      pend_rsp.delete();
      out_m    = 0;
      exp_done = 1'b0;
      prot_m   = 1'b0;
      err_m    = 0;
    end else begin
      ok = rv && (out_m > 0 || iss);
      exp_done = ok;
      if (rv && !ok) prot_m = 1'b1;
      if (ok && re && err_m < 255) err_m++;
      if (ok && pend_rsp.size() > 0)
        void'(pend_rsp.pop_front());
      if (push) begin
        fifo_m.push_back({wr_addr, wr_data});
        n_acc++;
      end
      if (iss) begin
        void'(fifo_m.pop_front());
        e = 1'b0;
        if (err_q.size() > 0) e = err_q.pop_front();
        pend_rsp.push_back(e);
      end
      out_m = out_m + int'(iss) - int'(ok);
    end
    if (wr_done) n_done++;
    chk("wr_done", wr_done, exp_done);
    chk("pending", pending, fifo_m.size() + out_m);
    chk("busy", busy, (fifo_m.size() + out_m) != 0);
    chk("err_count", err_count, err_m);
    chk("protocol_err", protocol_err, prot_m);
    inj_rsp = 1'b0;
    rsp_once = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
  endtask

  task automatic send(logic [AW-1:0] a, logic [DW-1:0] d);
    bit acc;
    int k;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 500) begin
      acc = wr_ready;
      cycle();
      k++;
    end
    chk("send_timeout", acc, 1);
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    auto_rsp = 1'b1;
    mem_rdy  = 1'b1;
    while (busy && k < 2000) begin
      cycle();
      k++;
    end
    chk("drain_timeout", busy, 0);
    cycle();
    cycle();
    chk("done_count", n_done, n_acc);
    n_done = 0;
    n_acc  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, first, pulses;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
    mem_rdy = 1'b0;
    auto_rsp = 1'b0;
    rsp_once = 1'b0;
    inj_rsp = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_data", mem_req_data, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_pending", pending, 0);

    // single write latency
    mem_rdy = 1'b1;
    auto_rsp = 1'b1;
    send(32'h100, 32'hA5);
    t0 = cyc;
    chk("t1_req_valid", mem_req_valid, 1);
    chk("t1_addr", mem_req_addr, 32'h100);
    chk("t1_data", mem_req_data, 32'hA5);
    first = -1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (wr_done) begin
        pulses++;
        if (first < 0) first = cyc - t0;
      end
    end
    chk("t1_latency", first, 2);
    chk("t1_pulses", pulses, 1);
    drain();

    // fifo full under memory back-pressure
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h200 + i, 32'h50 + i);
    wr_valid = 1'b1;
    wr_addr = 32'h204;
    wr_data = 32'h54;
    for (int i = 0; i < 3; i++) begin
      chk("t2_full", wr_ready, 0);
      cycle();
    end
    mem_rdy = 1'b1;
    send(32'h204, 32'h54);
    chk("t2_acc", n_acc, 5);
    drain();

    // outstanding limit
    mem_rdy = 1'b1;
    auto_rsp = 1'b0;
    for (int i = 0; i < 6; i++)
      send(32'h300 + i, 32'h60 + i);
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_hold", mem_req_valid, 0);
    chk("t3_pending", pending, 6);
    rsp_once = 1'b1;
    cycle();
    chk("t3_reissue", mem_req_valid, 1);
    cycle();
    chk("t3_one_only", mem_req_valid, 0);
    chk("t3_pending2", pending, 5);
    drain();

    // error responses and saturation
    err_q.push_back(1'b0);
    err_q.push_back(1'b1);
    err_q.push_back(1'b0);
    for (int i = 0; i < 3; i++)
      send(32'h400 + i, 32'h70 + i);
    drain();
    chk("t4_err1", err_count, 1);
    for (int i = 0; i < 300; i++) begin
      err_q.push_back(1'b1);
      send(32'h1000 + i, $urandom);
    end
    drain();
    chk("t4_sat", err_count, 255);

    // response with nothing outstanding
    inj_rsp = 1'b1;
    cycle();
    chk("t5_prot", protocol_err, 1);
    chk("t5_no_done", wr_done, 0);
    chk("t5_pending", pending, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_sticky", protocol_err, 1);

    // reset mid-operation
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_prot_clr", protocol_err, 0);
    chk("t6_err_clr", err_count, 0);
    n_acc = 0;
    n_done = 0;
    mem_rdy = 1'b1;
    auto_rsp = 1'b0;
    send(32'h500, 32'h11);
    send(32'h504, 32'h22);
    cycle();
    mem_rdy = 1'b0;
    send(32'h508, 32'h33);
    send(32'h50C, 32'h44);
    chk("t6_pend_pre", pending, 4);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_pending", pending, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_done", wr_done, 0);
    chk("t6_req_valid", mem_req_valid, 0);
    n_done = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_no_done", n_done, 0);
    inj_rsp = 1'b1;
    cycle();
    chk("t6_prot", protocol_err, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_write_responder.md
Name: mc_write_responder

Overview:
- Per-port responder for multicast write traffic. One instance sits on each switch port, on the far side of the multicast write fan-out.
- Accepts write requests (valid/ready), buffers them in a small FIFO, issues them in order to the node memory interface, and tracks memory responses.
- Returns a single-cycle write-done pulse per completed write. The multicast initiator collects these pulses as acknowledgments.

Parameters:
- ADDR_WIDTH, tswitch_pkg::ADDR_WIDTH, address width.
- DATA_WIDTH, tswitch_pkg::DATA_WIDTH, data width.
- FIFO_DEPTH, 4, request buffer entries; power of 2, minimum 2.
- MAX_OUTSTANDING, 4, maximum memory writes issued but not yet responded; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  write request valid.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  request accepted when wr_valid && wr_ready.
- wr_done  out  1  one-cycle pulse per completed write.
- mem_req_valid  out  1  memory write request valid.
- mem_req_addr  out  ADDR_WIDTH  memory write address.
- mem_req_data  out  DATA_WIDTH  memory write data.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  one write completion; completions return in issue order.
- mem_rsp_error  in  1  qualifies mem_rsp_valid; the write failed.
- err_count  out  8  saturating count of error responses.
- protocol_err  out  1  sticky; set by a response arriving with nothing outstanding.
- pending  out  $clog2(FIFO_DEPTH+MAX_OUTSTANDING+1)  FIFO occupancy plus outstanding count.
- busy  out  1  high when pending != 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n); it is sampled only on the clk rising edge.
- Reset state: FIFO empty, outstanding = 0, all outputs 0 except wr_ready = 1.
  - Reset mid-operation drops all buffered and outstanding writes.
  - No wr_done is generated for dropped writes.
- Accept:
  - wr_ready = !fifo_full; it is a function of registered state only.
  - On wr_valid && wr_ready, push {wr_addr, wr_data} into the FIFO.
- Issue:
  - mem_req_valid = !fifo_empty && (outstanding < MAX_OUTSTANDING).
  - mem_req_addr and mem_req_data come from the FIFO head. They are held stable while mem_req_valid && !mem_req_ready.
  - On the mem_req handshake, pop the FIFO and increment outstanding.
- Push and pop in the same cycle: both take effect. A pop while full frees space on the next cycle only; there is no same-cycle pass-through.
- Completion:
  - mem_rsp_valid with outstanding > 0 decrements outstanding.
  - Issue and response in the same cycle leave outstanding unchanged.
  - wr_done is registered: it pulses the cycle after each valid response.
  - An error response still produces wr_done, so the initiator never hangs. It also increments err_count, which saturates at 255.
- Protocol error:
  - mem_rsp_valid with outstanding == 0 (and no same-cycle issue) sets protocol_err.
  - No decrement and no wr_done in that case.
- Latency: request accepted at cycle N → earliest mem_req_valid at N+1 → earliest response at N+2 → earliest wr_done at N+3.
- Throughput: one request per cycle sustained when memory is always ready.
- Ordering: wr_done pulses appear in acceptance order; the count of wr_done pulses equals the count of accepted writes.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits and full/empty are pointer-compare based. Every wrap must be correct.
- Back-pressure:
  - FIFO full → wr_ready = 0.
  - Outstanding == MAX_OUTSTANDING → mem_req_valid = 0 and the FIFO holds.

Test Plan:
- Reset, then single write addr 0x100 data 0xA5, memory always ready, response 1 cycle after issue → mem_req at N+1 carrying 0x100/0xA5; wr_done pulses exactly once at N+3; busy drops the cycle after.
- mem_req_ready held low, 5 writes offered back-to-back → first 4 accepted, wr_ready = 0 on the 5th until ready rises; memory sees addr/data in order; 5 wr_done pulses total.
- MAX_OUTSTANDING = 4, memory ready, responses withheld → 4 issues, then mem_req_valid = 0 while FIFO entries remain; one response → exactly one more issue next cycle.
- 3 writes with the 2nd response carrying mem_rsp_error = 1 → 3 wr_done pulses, err_count = 1; 300 error responses → err_count = 255.
- mem_rsp_valid injected with outstanding = 0 → protocol_err = 1 and held; no wr_done; pending unchanged.
- Assert rst_n = 0 with 2 writes buffered and 2 outstanding → next cycle pending = 0, wr_ready = 1, no wr_done; a later response sets protocol_err.
